// File: rtl/fpu_norm_round_pipe.sv
// fpu_norm_round_pipe: two-stage normalizer/rounder turning a prenormalized {sign, exp, mant} triple into an IEEE-754 single.
//   Stage 1 counts leading zeros, left-justifies the mantissa and adjusts the exponent.
//   Stage 2 rounds to 23 fraction bits, handles overflow/underflow/zero and registers the packed result.
//   Ports: Clk_CI, Rst_RI (async, active-high); In_valid_SI/In_ready_SO, Sign_prenorm_DI, Exp_prenorm_DI,
//   Mant_prenorm_DI, RM_SI on the input side; Out_valid_SO/Out_ready_SI, Result_DO, OF_SO, UF_SO, NX_SO on the output side.
//   Define FPU_NORM_RMODE_EN to honour RM_SI; otherwise rounding is fixed to round-to-nearest-even.
module fpu_norm_round_pipe #(
    parameter int MANT_W = 48,
    parameter int EXP_W  = 10,
    parameter int BIAS   = 127
) (
    input  logic              Clk_CI,
    input  logic              Rst_RI,
    input  logic              In_valid_SI,
    output logic              In_ready_SO,
    input  logic              Sign_prenorm_DI,
    input  logic [EXP_W-1:0]  Exp_prenorm_DI,
    input  logic [MANT_W-1:0] Mant_prenorm_DI,
    input  logic [1:0]        RM_SI,
    output logic              Out_valid_SO,
    input  logic              Out_ready_SI,
    output logic [31:0]       Result_DO,
    output logic              OF_SO,
    output logic              UF_SO,
    output logic              NX_SO
);
    localparam int LZ_W = $clog2(MANT_W);
    localparam logic signed [EXP_W:0] EXP_MAX = (EXP_W+1)'(2 * BIAS + 1);
    localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RDN = 2'b10;

    logic [LZ_W-1:0]     lz;
    logic signed [EXP_W:0] exp_n;
    logic [MANT_W-2:0]   mant_n;
    logic                s1_valid, s1_sign, s1_zero, s2_ready;
    logic signed [EXP_W:0] s1_exp;
    logic [MANT_W-2:0]   s1_mant;
    logic [1:0]          rm;

    always_comb begin
        lz = '0;
        for (int i = 0; i < MANT_W; i++)
            if (Mant_prenorm_DI[i]) lz = LZ_W'(MANT_W - 1 - i);
    end

    // The hidden bit lands in bit MANT_W-1 after the shift and is implied, so only the bits below it are kept.
    assign mant_n = Mant_prenorm_DI[MANT_W-2:0] << lz;
    assign exp_n  = {Exp_prenorm_DI[EXP_W-1], Exp_prenorm_DI} + (EXP_W+1)'(1) - (EXP_W+1)'(lz);

    assign s2_ready    = !Out_valid_SO | Out_ready_SI;
    assign In_ready_SO = !s1_valid | s2_ready;

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
        end else if (In_ready_SO) begin
            s1_valid <= In_valid_SI;
            if (In_valid_SI) begin
                s1_sign <= Sign_prenorm_DI;
                s1_zero <= Mant_prenorm_DI == '0;
                s1_exp  <= exp_n;
                s1_mant <= mant_n;
            end
        end
    end

`ifdef FPU_NORM_RMODE_EN
    logic [1:0] s1_rm;
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) s1_rm <= RNE;
        else if (In_ready_SO && In_valid_SI) s1_rm <= RM_SI;
    end
    assign rm = s1_rm;
`else
    logic unused_rm;
    assign unused_rm = ^RM_SI;
    assign rm = RNE;
`endif

    logic [22:0]           frac, frac_r;
    logic                  g, st, inc, carry, ovf, unf, to_inf;
    logic signed [EXP_W:0] exp_r;
    logic [31:0]           res;

    assign frac   = s1_mant[MANT_W-2 -: 23];
    assign g      = s1_mant[MANT_W-25];
    assign st     = |s1_mant[MANT_W-26:0];
    assign inc    = rm == RNE ? g & (st | frac[0]) : rm == RTZ ? 1'b0 : rm == RDN ? (g | st) & s1_sign : (g | st) & !s1_sign;
    assign {carry, frac_r} = {1'b0, frac} + 24'(inc);
    assign exp_r  = s1_exp + (EXP_W+1)'(carry);
    assign ovf    = !exp_r[EXP_W] && exp_r >= EXP_MAX;
    assign unf    = exp_r[EXP_W] || exp_r == '0;
    // Overflow rounds to infinity only when the rounding direction points away from zero.
    assign to_inf = rm == RNE || (rm == RDN && s1_sign) || (rm != RTZ && rm != RDN && !s1_sign);
    assign res    = s1_zero ? {s1_sign, 31'b0} :
                    ovf     ? (to_inf ? {s1_sign, 8'hFF, 23'b0} : {s1_sign, 31'h7F7FFFFF}) :
                    unf     ? {s1_sign, 31'b0} : {s1_sign, exp_r[7:0], frac_r};

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            Out_valid_SO <= 1'b0;
            Result_DO    <= '0;
            OF_SO        <= 1'b0;
            UF_SO        <= 1'b0;
            NX_SO        <= 1'b0;
        end else if (s2_ready) begin
            Out_valid_SO <= s1_valid;
            if (s1_valid) begin
                Result_DO <= res;
                OF_SO     <= !s1_zero & ovf;
                UF_SO     <= !s1_zero & !ovf & unf;
                NX_SO     <= !s1_zero & (ovf | unf | g | st);
            end
        end
    end
endmodule

// File: tb/tb_fpu_norm_round_pipe.sv
// tb_fpu_norm_round_pipe: directed self-checking bench for fpu_norm_round_pipe.
module tb_fpu_norm_round_pipe;
    logic        clk = 0, rst = 1, in_valid = 0, in_ready, sign_in = 0;
    logic        out_valid, out_ready = 1, of, uf, nx;
    logic [9:0]  exp_in = '0;
    logic [47:0] mant_in = '0;
    logic [1:0]  rm = '0;
    logic [31:0] result;
    int errors = 0, checks = 0;

`ifdef FPU_NORM_RMODE_EN
    localparam logic [31:0] EXP_RTZ_MAX = 32'h4EFFFFFF, EXP_RUP_TIE = 32'h4B800001, EXP_OF_RTZ = 32'h7F7FFFFF;
`else
    localparam logic [31:0] EXP_RTZ_MAX = 32'h4F000000, EXP_RUP_TIE = 32'h4B800000, EXP_OF_RTZ = 32'h7F800000;
`endif

    logic [31:0] r;
    logic        o, u, x, v1, v2;
    logic [31:0] got [3];
    int          n_got, n_sent;
    logic        stall_seen, never_stalled;
    logic [47:0] s_mant [3] = '{48'h0000_0001_0000, 48'h8000_0000_0000, 48'h7FFF_FFFF_0000};
    logic        s_sign [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] s_exp  [3] = '{32'h3F800000, 32'hCF000000, 32'h4F000000};

    always #5 clk = ~clk;

    fpu_norm_round_pipe dut (
        .Clk_CI(clk), .Rst_RI(rst), .In_valid_SI(in_valid), .In_ready_SO(in_ready),
        .Sign_prenorm_DI(sign_in), .Exp_prenorm_DI(exp_in), .Mant_prenorm_DI(mant_in), .RM_SI(rm),
        .Out_valid_SO(out_valid), .Out_ready_SI(out_ready), .Result_DO(result),
        .OF_SO(of), .UF_SO(uf), .NX_SO(nx)
    );

    task automatic op(input logic s, input logic [9:0] e, input logic [47:0] m, input logic [1:0] mode);
        @(negedge clk);
        out_ready = 1; in_valid = 1; sign_in = s; exp_in = e; mant_in = m; rm = mode;
        @(negedge clk);
        in_valid = 0; v1 = out_valid;
        @(negedge clk);
        v2 = out_valid; r = result; o = of; u = uf; x = nx;
    endtask

    task automatic stream(input int ready_at);
        n_got = 0; n_sent = 0; stall_seen = 1; never_stalled = 1;
        for (int c = 0; c < 40 && n_got < 3; c++) begin
            @(negedge clk);
            out_ready = c >= ready_at;
            in_valid = n_sent < 3;
            if (n_sent < 3) begin sign_in = s_sign[n_sent]; exp_in = 10'd157; mant_in = s_mant[n_sent]; rm = 2'b00; end
            #1;
            if (c >= 2 && c < ready_at && in_ready !== 1'b0) stall_seen = 0;
            if (in_valid && !in_ready) never_stalled = 0;
            if (out_valid && out_ready) begin got[n_got] = result; n_got++; end
            if (in_valid && in_ready) n_sent++;
        end
        @(negedge clk);
        in_valid = 0; out_ready = 1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=00000000", result); end
        checks++; if ({of, uf, nx} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {of, uf, nx}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        rst = 0;
    endtask

    task automatic test_exact;
        op(1'b0, 10'd157, 48'h0000_0001_0000, 2'b00);
        checks++; if ({v1, v2} !== 2'b01) begin errors++; $display("FAIL int1_latency got=%b exp=01", {v1, v2}); end
        checks++; if (r !== 32'h3F800000) begin errors++; $display("FAIL int1_result got=%h exp=3f800000", r); end
        checks++; if ({o, u, x} !== 3'b000) begin errors++; $display("FAIL int1_flags got=%b exp=000", {o, u, x}); end
        op(1'b1, 10'd157, 48'h8000_0000_0000, 2'b00);
        checks++; if (r !== 32'hCF000000) begin errors++; $display("FAIL neg2p31_result got=%h exp=cf000000", r); end
        checks++; if (x !== 1'b0) begin errors++; $display("FAIL neg2p31_nx got=%b exp=0", x); end
    endtask

    task automatic test_rounding;
        op(1'b0, 10'd157, 48'h7FFF_FFFF_0000, 2'b00);
        checks++; if (r !== 32'h4F000000) begin errors++; $display("FAIL max_rne got=%h exp=4f000000", r); end
        checks++; if (x !== 1'b1) begin errors++; $display("FAIL max_rne_nx got=%b exp=1", x); end
        op(1'b0, 10'd157, 48'h7FFF_FFFF_0000, 2'b01);
        checks++; if (r !== EXP_RTZ_MAX) begin errors++; $display("FAIL max_rtz got=%h exp=%h", r, EXP_RTZ_MAX); end
        checks++; if (x !== 1'b1) begin errors++; $display("FAIL max_rtz_nx got=%b exp=1", x); end
        op(1'b0, 10'd157, 48'h0100_0001_0000, 2'b00);
        checks++; if (r !== 32'h4B800000) begin errors++; $display("FAIL tie_rne got=%h exp=4b800000", r); end
        checks++; if ({o, u, x} !== 3'b001) begin errors++; $display("FAIL tie_rne_flags got=%b exp=001", {o, u, x}); end
        op(1'b0, 10'd157, 48'h0100_0001_0000, 2'b11);
        checks++; if (r !== EXP_RUP_TIE) begin errors++; $display("FAIL tie_rup got=%h exp=%h", r, EXP_RUP_TIE); end
    endtask

    task automatic test_special;
        op(1'b0, 10'd157, 48'h0, 2'b00);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL zero_result got=%h exp=00000000", r); end
        checks++; if ({o, u, x} !== 3'b000) begin errors++; $display("FAIL zero_flags got=%b exp=000", {o, u, x}); end
        op(1'b1, 10'd20, 48'h0, 2'b00);
        checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL negzero_result got=%h exp=80000000", r); end
        op(1'b0, 10'd300, 48'h4000_0000_0000, 2'b00);
        checks++; if (r !== 32'h7F800000) begin errors++; $display("FAIL of_rne got=%h exp=7f800000", r); end
        checks++; if ({o, u, x} !== 3'b101) begin errors++; $display("FAIL of_flags got=%b exp=101", {o, u, x}); end
        op(1'b0, 10'd300, 48'h4000_0000_0000, 2'b01);
        checks++; if (r !== EXP_OF_RTZ) begin errors++; $display("FAIL of_rtz got=%h exp=%h", r, EXP_OF_RTZ); end
        op(1'b1, 10'd10, 48'h0000_0001_0000, 2'b00);
        checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL uf_result got=%h exp=80000000", r); end
        checks++; if ({o, u, x} !== 3'b011) begin errors++; $display("FAIL uf_flags got=%b exp=011", {o, u, x}); end
    endtask

    task automatic test_backpressure;
        stream(5);
        checks++; if (stall_seen !== 1'b1) begin errors++; $display("FAIL bp_in_ready_drop got=%b exp=1", stall_seen); end
        checks++; if (n_got !== 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", n_got); end
        for (int i = 0; i < n_got; i++) begin
            checks++; if (got[i] !== s_exp[i]) begin errors++; $display("FAIL bp_order%0d got=%h exp=%h", i, got[i], s_exp[i]); end
        end
    endtask

    task automatic test_back_to_back;
        stream(0);
        checks++; if (never_stalled !== 1'b1) begin errors++; $display("FAIL b2b_stall got=%b exp=1", never_stalled); end
        checks++; if (n_got !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", n_got); end
        for (int i = 0; i < n_got; i++) begin
            checks++; if (got[i] !== s_exp[i]) begin errors++; $display("FAIL b2b_order%0d got=%h exp=%h", i, got[i], s_exp[i]); end
        end
    endtask

    task automatic test_reset_mid;
        logic leak;
        @(negedge clk);
        out_ready = 0; in_valid = 1; sign_in = 0; exp_in = 10'd157; mant_in = 48'h0000_0001_0000; rm = 0;
        @(negedge clk);
        mant_in = 48'h8000_0000_0000;
        @(negedge clk);
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_prefill got=%b exp=1", out_valid); end
        rst = 1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rstmid_result got=%h exp=00000000", result); end
        rst = 0; out_ready = 1; leak = 0;
        repeat (5) begin @(negedge clk); if (out_valid) leak = 1; end
        checks++; if (leak !== 1'b0) begin errors++; $display("FAIL rstmid_leak got=%b exp=0", leak); end
    endtask

    initial begin
        test_reset;
        test_exact;
        test_rounding;
        test_special;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
